// File: rtl/module_types.sv
// rtl/module_types.sv - shared types for dmem_arbiter; FWD state exists only with DMEM_ARB_STORE_FWD_EN
package module_types;

   localparam int WORD_OFFSET_BITS = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } store_buf_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_WAIT,
`ifdef DMEM_ARB_STORE_FWD_EN
      STORE_WAIT,
      FWD
`else
      STORE_WAIT
`endif
   } dmem_arb_state_t;

endpackage

// File: rtl/dmem_hazard_check.sv
// rtl/dmem_hazard_check.sv - same-word load/store overlap detection
module dmem_hazard_check
   import module_types::*;
(
   input  logic [31:0]      i_load_addr,
   input  logic [3:0]       i_load_rmask,
   input  store_buf_entry_t i_store_entry,
   input  logic             i_store_valid,
   output logic             o_hazard,
   output logic             o_fwd_ok
);

   logic w_same_word;
   logic w_unused;

   assign w_same_word = i_load_addr[31:WORD_OFFSET_BITS] == i_store_entry.addr[31:WORD_OFFSET_BITS];
   assign o_hazard    = i_store_valid && w_same_word && ((i_load_rmask & i_store_entry.wmask) != 4'b0);
   // Forwarding is only safe when the store covers every byte the load reads.
   assign o_fwd_ok    = o_hazard && ((i_load_rmask & ~i_store_entry.wmask) == 4'b0);

   assign w_unused = ^{i_load_addr[WORD_OFFSET_BITS-1:0],
                       i_store_entry.addr[WORD_OFFSET_BITS-1:0],
                       i_store_entry.wdata};

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - load / store-buffer arbiter in front of the data memory port
// Store-to-load forwarding is built when DMEM_ARB_STORE_FWD_EN is defined.
module dmem_arbiter
   import module_types::*;
#(
   parameter int STARVE_LIMIT = 4
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             load_req_valid,
   output logic             load_req_ready,
   input  logic [31:0]      load_req_addr,
   input  logic [3:0]       load_req_rmask,
   output logic             load_resp_valid,
   output logic [31:0]      load_resp_rdata,
   input  logic             store_valid,
   input  store_buf_entry_t store_entry,
   output logic             store_done,
   output logic [31:0]      dmem_addr,
   output logic [3:0]       dmem_rmask,
   output logic [3:0]       dmem_wmask,
   output logic [31:0]      dmem_wdata,
   input  logic             dmem_resp,
   input  logic [31:0]      dmem_rdata
);

   localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   dmem_arb_state_t r_state;
   dmem_arb_state_t w_next_state;

   logic [CNT_W-1:0] r_starve_cnt;
   logic             r_kill;
   logic [31:0]      r_dmem_addr;
   logic [3:0]       r_dmem_rmask;
   logic [3:0]       r_dmem_wmask;
   logic [31:0]      r_dmem_wdata;
   logic             r_resp_valid;
   logic [31:0]      r_resp_rdata;
   logic             r_store_done;

   logic w_hazard;
   logic w_fwd_ok;
   logic w_load_ok;
   logic w_force;
   logic w_grant_load;
   logic w_grant_store;
   logic w_grant_fwd;

   dmem_hazard_check u_hazard (
      .i_load_addr   (load_req_addr),
      .i_load_rmask  (load_req_rmask),
      .i_store_entry (store_entry),
      .i_store_valid (store_valid),
      .o_hazard      (w_hazard),
      .o_fwd_ok      (w_fwd_ok)
   );

   assign w_load_ok = load_req_valid && !flush;
   assign w_force   = store_valid && (r_starve_cnt == CNT_MAX);

   always_comb begin
      w_grant_load  = 1'b0;
      w_grant_store = 1'b0;
      w_grant_fwd   = 1'b0;
      if (r_state == IDLE) begin
         if (w_force) begin
            w_grant_store = 1'b1;
         end else if (w_load_ok && w_hazard) begin
`ifdef DMEM_ARB_STORE_FWD_EN
            if (w_fwd_ok) begin
               w_grant_fwd = 1'b1;
            end else begin
               w_grant_store = 1'b1;
            end
`else
            w_grant_store = 1'b1;
`endif
         end else if (w_load_ok) begin
            w_grant_load = 1'b1;
         end else if (store_valid) begin
            w_grant_store = 1'b1;
         end
      end
   end

`ifndef DMEM_ARB_STORE_FWD_EN
   logic w_unused_fwd;
   assign w_unused_fwd = w_fwd_ok;
`endif

   assign load_req_ready = rst && (w_grant_load || w_grant_fwd);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant_load) begin
               w_next_state = LOAD_WAIT;
            end else if (w_grant_store) begin
               w_next_state = STORE_WAIT;
`ifdef DMEM_ARB_STORE_FWD_EN
            end else if (w_grant_fwd) begin
               w_next_state = FWD;
`endif
            end
         end
         LOAD_WAIT:  if (dmem_resp) w_next_state = IDLE;
         STORE_WAIT: if (dmem_resp) w_next_state = IDLE;
         default:    w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Counts loads that win while a store waits; any store grant or empty buffer resets it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_starve_cnt <= '0;
      end else if (w_grant_store || !store_valid) begin
         r_starve_cnt <= '0;
      end else if ((w_grant_load || w_grant_fwd) && (r_starve_cnt != CNT_MAX)) begin
         r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_kill       <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_rmask <= '0;
         r_dmem_wmask <= '0;
         r_dmem_wdata <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_store_done <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         r_store_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_kill <= 1'b0;
               if (w_grant_load) begin
                  r_dmem_addr  <= {load_req_addr[31:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};
                  r_dmem_rmask <= load_req_rmask;
                  r_dmem_wmask <= 4'b0;
               end else if (w_grant_store) begin
                  r_dmem_addr  <= {store_entry.addr[31:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};
                  r_dmem_wmask <= store_entry.wmask;
                  r_dmem_wdata <= store_entry.wdata;
                  r_dmem_rmask <= 4'b0;
               end else if (w_grant_fwd) begin
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= store_entry.wdata;
               end
            end
            LOAD_WAIT: begin
               if (dmem_resp) begin
                  r_dmem_rmask <= 4'b0;
                  r_resp_valid <= !(r_kill || flush);
                  r_resp_rdata <= dmem_rdata;
                  r_kill       <= 1'b0;
               end else if (flush) begin
                  r_kill <= 1'b1;
               end
            end
            STORE_WAIT: begin
               if (dmem_resp) begin
                  r_dmem_wmask <= 4'b0;
                  r_store_done <= 1'b1;
               end
            end
            default: begin
               r_kill <= 1'b0;
            end
         endcase
      end
   end

`ifdef DMEM_ARB_STORE_FWD_EN
   // The forwarded response is already registered, so a flush in FWD masks it here.
   assign load_resp_valid = r_resp_valid && !((r_state == FWD) && flush);
`else
   assign load_resp_valid = r_resp_valid;
`endif

   assign load_resp_rdata = r_resp_rdata;
   assign store_done      = r_store_done;
   assign dmem_addr       = r_dmem_addr;
   assign dmem_rmask      = r_dmem_rmask;
   assign dmem_wmask      = r_dmem_wmask;
   assign dmem_wdata      = r_dmem_wdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the load unit and the store buffer. It accepts load requests and committed stores from the store buffer's top entry and issues them one at a time to the data-memory interface. It resolves same-word load/store hazards and returns load data and store-drain acknowledgements. It sits directly downstream of the store buffer and in front of the data memory/cache port.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive cycles a valid store may lose arbitration to loads before it is forced first.

Ports (types from `module_types`):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset: synchronous, active-low; low on a rising edge resets all state.
- flush  in  1  pipeline flush (mispredict); kills in-flight/accepted load only.
- load_req_valid  in  1  load request valid.
- load_req_ready  out  1  arbiter accepts load this cycle.
- load_req_addr  in  32  byte address; word-aligned access.
- load_req_rmask  in  4  byte read mask, nonzero.
- load_resp_valid  out  1  one-cycle pulse, load data valid.
- load_resp_rdata  out  32  raw word, unextended.
- store_valid  in  1  store buffer holds a drainable store (not empty).
- store_entry  in  store_buf_entry_t  top entry, fields addr[31:0], wdata[31:0], wmask[3:0].
- store_done  out  1  one-cycle pulse, store written to memory.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_rmask  out  4  read mask; nonzero marks read.
- dmem_wmask  out  4  write mask; nonzero marks write.
- dmem_wdata  out  32  write data.
- dmem_resp  in  1  memory completion pulse.
- dmem_rdata  in  32  read data, valid with dmem_resp.

## Operation
- FSM states: IDLE, LOAD_WAIT, STORE_WAIT, FWD.
- IDLE grant rules, evaluated combinationally. Priority order:
  1. Store forced: store_valid and starve_cnt == STARVE_LIMIT → store.
  2. Hazard: load_req_valid, store_valid, load word addr == store word addr, and (rmask & wmask) != 0 → store first. Exception: the forward case (see Configuration).
  3. load_req_valid → load.
  4. store_valid → store.
- load_req_ready = 1 only in IDLE when a load is granted (normal or forward).
- Load grant → dmem_addr/dmem_rmask registered, dmem_wmask = 0 → LOAD_WAIT.
- Store grant → dmem_addr/dmem_wmask/dmem_wdata registered from store_entry, dmem_rmask = 0 → STORE_WAIT.
- dmem_* outputs are held stable until dmem_resp. On dmem_resp, masks clear to 0 and the FSM returns to IDLE.
- LOAD_WAIT + dmem_resp → capture rdata, load_resp_valid next cycle, unless killed.
- STORE_WAIT + dmem_resp → store_done next cycle.
- starve_cnt (saturating, width $clog2(STARVE_LIMIT+1)):
  - increments each IDLE cycle where store_valid is high and a load is granted;
  - clears on store grant or when store_valid is low.
- flush:
  - in IDLE: no load accepted that cycle;
  - in LOAD_WAIT: sets kill flag; transaction completes to memory, load_resp_valid suppressed;
  - in FWD: suppresses the pending response;
  - STORE_WAIT unaffected.
- dmem_resp outside WAIT states is ignored.
- Reset: state IDLE, starve_cnt 0, kill 0; all outputs 0 (load_req_ready 0 during reset).

## Timing
- Cycle N: IDLE grant; load_req_ready high for loads.
- Cycle N+1: dmem request visible.
- Cycle M: dmem_resp (M ≥ N+1; zero-wait memory responds at N+1).
- Cycle M+1: load_resp_valid or store_done pulse; FSM already in IDLE, so a new grant is possible in M+1.
- Minimum 2 cycles per transaction; one outstanding memory transaction maximum.
- Forward: accept at N, load_resp_valid at N+1, no dmem activity.
- rst low mid-transaction: state aborts to IDLE, outputs 0. A late dmem_resp after reset is ignored.

## Configuration
- `DMEM_ARB_STORE_FWD_EN` defined:
  - A hazard where (rmask & ~wmask) == 0 forwards: state FWD, response data = store_entry.wdata captured at grant.
  - Partial overlap still stalls for the store.
  - The store remains in the buffer and drains normally.
- Undefined: every hazard drains the store first. FWD state is not present.

## Structure
- Shared package `module_types`:
  - store_buf_entry_t;
  - dmem_arb_state_t enum;
  - localparam WORD_OFFSET_BITS = 2.
- Sub-module `dmem_hazard_check` (combinational): inputs load addr/rmask, store entry, store_valid. Outputs hazard and fwd_ok.
- FSM, starvation counter and output registers live in the top.

## Test plan
- Load only: addr 0x100, rmask 4'hF; dmem_resp at N+3, rdata 0xDEADBEEF → load_resp_valid at N+4 with 0xDEADBEEF; dmem_wmask stays 0.
- Store only: entry {0x200, 0x12345678, 4'h3}, zero-wait memory → dmem_wmask 4'h3 at N+1; store_done at N+2.
- Hazard: load 0x200 rmask 4'h1 plus store 0x200 wmask 4'h3:
  - forward defined → load_resp_valid at N+1 with 0x12345678, no dmem access;
  - undefined → store issues first, load follows after store_done.
- Starvation: STARVE_LIMIT=4, continuous non-conflicting loads plus store_valid → store granted on the 5th IDLE grant.
- Flush during LOAD_WAIT → dmem_resp consumed, no load_resp_valid; next load proceeds normally.
- rst low in STORE_WAIT → next cycle all outputs 0, state IDLE; subsequent stray dmem_resp produces no store_done.
